// File: rtl/udp_depacketizer_if.sv
// Stream bundle between the MAC RX FIFO, the UDP depacketizer and the downstream Deserializer.
// The depacketizer uses the slave view; the environment driving rx_* uses the master view.
interface udp_depacketizer_if;
  logic [31:0] rx_data;
  logic        rx_sop;
  logic        rx_eop;
  logic [1:0]  rx_mod;
  logic [5:0]  rx_err;
  logic        rx_dval;
  logic        rx_rdy;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        out_err;

  modport master (
    output rx_data, rx_sop, rx_eop, rx_mod, rx_err, rx_dval, out_ready,
    input  rx_rdy, out_data, out_valid, out_sop, out_eop, out_err
  );

  modport slave (
    input  rx_data, rx_sop, rx_eop, rx_mod, rx_err, rx_dval, out_ready,
    output rx_rdy, out_data, out_valid, out_sop, out_eop, out_err
  );
endinterface

// File: rtl/udp_depacketizer.sv
// Parses Ethernet/IPv4/UDP headers from the shift16 MAC RX stream and forwards the UDP payload.
// Optional IPv4 header checksum check: define IP_CSUM_CHECK_EN.
module udp_depacketizer #(
  parameter logic [47:0] local_mac  = 48'h021234566790,
  parameter logic [31:0] local_ip   = 32'h0A000002,
  parameter logic [15:0] local_port = 16'd32179
) (
  input  logic               clk,
  input  logic               rst,
  udp_depacketizer_if.slave  bus,
  output logic               abort,
  output logic [15:0]        good_cnt,
  output logic [15:0]        drop_cnt
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, TRAIL, DROP} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
  } out_beat_t;

  state_t    state, state_nxt;
  out_beat_t obuf, load_beat;
  logic      ovld, load;
  logic      beat, hdr_ok, csum_ok;
  logic      mac_hi_local, mac_hi_bcast;
  logic      first;
  logic      good_inc, abort_nxt;
  logic [1:0]  drop_inc;
  logic [3:0]  widx;
  logic [13:0] pcnt;
  logic [15:0] udp_len;

  assign bus.rx_rdy    = (state == PAYLOAD) ? (~ovld | bus.out_ready) : 1'b1;
  assign beat          = bus.rx_dval & bus.rx_rdy;
  assign udp_len       = bus.rx_data[31:16];
  assign bus.out_data  = obuf.data;
  assign bus.out_sop   = obuf.sop;
  assign bus.out_eop   = obuf.eop;
  assign bus.out_err   = obuf.err;
  assign bus.out_valid = ovld;

`ifdef IP_CSUM_CHECK_EN
  // Running one's-complement sum over w4..w8; each half is folded in with end-around carry.
  logic [15:0] csum, csum_nxt, f1;
  logic [16:0] s1, s2;

  always_comb begin
    s1       = {1'b0, (widx == 4'd4) ? 16'h0000 : csum} + {1'b0, bus.rx_data[31:16]};
    f1       = s1[15:0] + {15'd0, s1[16]};
    s2       = {1'b0, f1} + {1'b0, bus.rx_data[15:0]};
    csum_nxt = s2[15:0] + {15'd0, s2[16]};
    csum_ok  = (csum_nxt == 16'hFFFF);
  end

  always_ff @(posedge clk) begin
    if (rst)                         csum <= 16'h0000;
    else if (beat && state == HDR)   csum <= csum_nxt;
  end
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    hdr_ok = 1'b1;
    case (widx)
      4'd1:    hdr_ok = (mac_hi_local && bus.rx_data == local_mac[31:0]) ||
                        (mac_hi_bcast && bus.rx_data == 32'hFFFFFFFF);
      4'd3:    hdr_ok = (bus.rx_data[15:0] == 16'h0800);
      4'd4:    hdr_ok = (bus.rx_data[31:16] == 16'h4500);
      4'd5:    hdr_ok = (bus.rx_data[13:0] == 14'd0);
      4'd6:    hdr_ok = (bus.rx_data[23:16] == 8'd17);
      4'd8:    hdr_ok = (bus.rx_data == local_ip) && csum_ok;
      4'd9:    hdr_ok = (bus.rx_data[15:0] == local_port);
      4'd10:   hdr_ok = (udp_len >= 16'd12) && (udp_len[1:0] == 2'b00);
      default: hdr_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    load_beat.data = bus.rx_data;
    load_beat.sop  = first;
    load_beat.eop  = 1'b0;
    load_beat.err  = 1'b0;
    good_inc       = 1'b0;
    drop_inc       = 2'd0;
    abort_nxt      = 1'b0;
    if (beat) begin
      if (bus.rx_sop) begin
        // A new sop restarts parsing from any state; the cut-off frame is counted as dropped.
        if (state == HDR || state == DROP) drop_inc = 2'd1;
        if (state == PAYLOAD) begin
          drop_inc  = 2'd1;
          abort_nxt = 1'b1;
        end
        if (bus.rx_eop) begin
          drop_inc  = drop_inc + 2'd1;
          state_nxt = IDLE;
        end else begin
          state_nxt = HDR;
        end
      end else begin
        case (state)
          HDR: begin
            if (bus.rx_eop) begin
              drop_inc  = 2'd1;
              state_nxt = IDLE;
            end else if (!hdr_ok)       state_nxt = DROP;
            else if (widx == 4'd10)     state_nxt = PAYLOAD;
          end
          PAYLOAD: begin
            load = 1'b1;
            if (pcnt == 14'd1) begin
              load_beat.eop = 1'b1;
              load_beat.err = bus.rx_eop & ((|bus.rx_err) | (|bus.rx_mod));
              good_inc      = ~load_beat.err;
              state_nxt     = bus.rx_eop ? IDLE : TRAIL;
            end else if (bus.rx_eop) begin
              load_beat.eop = 1'b1;
              load_beat.err = 1'b1;
              state_nxt     = IDLE;
            end
          end
          TRAIL: begin
            if (bus.rx_eop) begin
              if (|bus.rx_err) drop_inc = 2'd1;
              state_nxt = IDLE;
            end
          end
          DROP: begin
            if (bus.rx_eop) begin
              drop_inc  = 2'd1;
              state_nxt = IDLE;
            end
          end
          default: ;  // IDLE without sop: leftover of a frame cut by reset
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obuf         <= '0;
      ovld         <= 1'b0;
      abort        <= 1'b0;
      good_cnt     <= 16'd0;
      drop_cnt     <= 16'd0;
      widx         <= 4'd0;
      pcnt         <= 14'd0;
      first        <= 1'b0;
      mac_hi_local <= 1'b0;
      mac_hi_bcast <= 1'b0;
    end else begin
      abort    <= abort_nxt;
      good_cnt <= good_cnt + {15'd0, good_inc};
      drop_cnt <= drop_cnt + {14'd0, drop_inc};
      if (beat && bus.rx_sop) begin
        widx         <= 4'd1;
        mac_hi_local <= (bus.rx_data[15:0] == local_mac[47:32]);
        mac_hi_bcast <= (bus.rx_data[15:0] == 16'hFFFF);
      end else if (beat && state == HDR) begin
        widx <= widx + 4'd1;
      end
      // N = (L-8)/4 = L/4 - 2
      if (beat && state == HDR && widx == 4'd10) begin
        pcnt  <= udp_len[15:2] - 14'd2;
        first <= 1'b1;
      end
      if (load) begin
        obuf  <= load_beat;
        ovld  <= 1'b1;
        first <= 1'b0;
        pcnt  <= pcnt - 14'd1;
      end else if (bus.out_ready) begin
        ovld  <= 1'b0;
      end
    end
  end

endmodule
